// File: rtl/bp_me_pkg.sv
// Shared opcode and coherence-state encodings for the LCE <-> cache memory-packet
// interface, plus the state encoding of the array clear sequencer.
package bp_me_pkg;

  typedef enum logic [2:0] {
    e_COH_I = 3'd0,
    e_COH_S = 3'd1,
    e_COH_E = 3'd2,
    e_COH_F = 3'd3,
    e_COH_M = 3'd6,
    e_COH_O = 3'd7
  } bp_coh_states_e;

  typedef enum logic [1:0] {
    e_tag_mem_set_clear = 2'd0,
    e_tag_mem_set_tag   = 2'd1,
    e_tag_mem_set_state = 2'd2,
    e_tag_mem_read      = 2'd3
  } bp_lce_tag_mem_opcode_e;

  typedef enum logic {
    e_data_mem_write = 1'b0,
    e_data_mem_read  = 1'b1
  } bp_lce_data_mem_opcode_e;

  typedef enum logic [1:0] {
    e_stat_mem_set_clear   = 2'd0,
    e_stat_mem_clear_dirty = 2'd1,
    e_stat_mem_set_dirty   = 2'd2,
    e_stat_mem_read        = 2'd3
  } bp_lce_stat_mem_opcode_e;

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_clear = 2'd1,
    e_ready = 2'd2
  } bp_lce_mem_clear_state_e;

endpackage

// File: rtl/bp_lce_cache_mem_responder_if.sv
// Tag/data/stat memory-packet bundle between an LCE (master) and the cache arrays (slave).
interface bp_lce_cache_mem_responder_if #(
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int block_width_p = 512,
  parameter int ctag_width_p  = 28,
  parameter int state_width_p = 3
);
  localparam int lg_sets_lp  = $clog2(sets_p);
  localparam int lg_assoc_lp = $clog2(assoc_p);

  // Handshake (all three channels, independent): the master raises *_v_i with a
  // stable packet and holds it until the slave's combinational *_yumi_o is seen
  // high at a clock edge; that edge consumes the packet. Read results appear on
  // *_mem_o the cycle after the consuming edge and hold until the next read.
  logic                               tag_mem_pkt_v_i;
  logic [1:0]                         tag_mem_pkt_opcode_i;
  logic [lg_sets_lp-1:0]              tag_mem_pkt_index_i;
  logic [lg_assoc_lp-1:0]             tag_mem_pkt_way_i;
  logic [ctag_width_p-1:0]            tag_mem_pkt_tag_i;
  logic [state_width_p-1:0]           tag_mem_pkt_state_i;
  logic                               tag_mem_pkt_yumi_o;
  logic [ctag_width_p+state_width_p-1:0] tag_mem_o;

  logic                               data_mem_pkt_v_i;
  logic                               data_mem_pkt_opcode_i;
  logic [lg_sets_lp-1:0]              data_mem_pkt_index_i;
  logic [lg_assoc_lp-1:0]             data_mem_pkt_way_i;
  logic [block_width_p-1:0]           data_mem_pkt_data_i;
  logic                               data_mem_pkt_yumi_o;
  logic [block_width_p-1:0]           data_mem_o;

  logic                               stat_mem_pkt_v_i;
  logic [1:0]                         stat_mem_pkt_opcode_i;
  logic [lg_sets_lp-1:0]              stat_mem_pkt_index_i;
  logic [lg_assoc_lp-1:0]             stat_mem_pkt_way_i;
  logic                               stat_mem_pkt_yumi_o;
  logic [(assoc_p-1)+assoc_p-1:0]     stat_mem_o;

  modport master (
    output tag_mem_pkt_v_i, tag_mem_pkt_opcode_i, tag_mem_pkt_index_i,
           tag_mem_pkt_way_i, tag_mem_pkt_tag_i, tag_mem_pkt_state_i,
    input  tag_mem_pkt_yumi_o, tag_mem_o,
    output data_mem_pkt_v_i, data_mem_pkt_opcode_i, data_mem_pkt_index_i,
           data_mem_pkt_way_i, data_mem_pkt_data_i,
    input  data_mem_pkt_yumi_o, data_mem_o,
    output stat_mem_pkt_v_i, stat_mem_pkt_opcode_i, stat_mem_pkt_index_i,
           stat_mem_pkt_way_i,
    input  stat_mem_pkt_yumi_o, stat_mem_o
  );

  modport slave (
    input  tag_mem_pkt_v_i, tag_mem_pkt_opcode_i, tag_mem_pkt_index_i,
           tag_mem_pkt_way_i, tag_mem_pkt_tag_i, tag_mem_pkt_state_i,
    output tag_mem_pkt_yumi_o, tag_mem_o,
    input  data_mem_pkt_v_i, data_mem_pkt_opcode_i, data_mem_pkt_index_i,
           data_mem_pkt_way_i, data_mem_pkt_data_i,
    output data_mem_pkt_yumi_o, data_mem_o,
    input  stat_mem_pkt_v_i, stat_mem_pkt_opcode_i, stat_mem_pkt_index_i,
           stat_mem_pkt_way_i,
    output stat_mem_pkt_yumi_o, stat_mem_o
  );

endinterface

// File: rtl/bp_lce_mem_clear_fsm.sv
// Reset/clear sequencer: after reset walks every set once (one per cycle), then
// reports init done. All outputs are registered.
module bp_lce_mem_clear_fsm
  import bp_me_pkg::*;
#(
  parameter int sets_p     = 64,
  localparam int lg_sets_lp = $clog2(sets_p)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  output logic                    o_clear_v,
  output logic [lg_sets_lp-1:0]   o_clear_idx,
  output logic                    o_init_done,
  output bp_lce_mem_clear_state_e o_state
);

  bp_lce_mem_clear_state_e r_state;
  logic [lg_sets_lp-1:0]   r_clear_idx;
  logic                    r_clear_v;
  logic                    r_init_done;

  // The counter stops at the last set rather than wrapping into e_ready.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state     <= e_reset;
      r_clear_idx <= '0;
      r_clear_v   <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        e_reset: begin
          r_state     <= e_clear;
          r_clear_idx <= '0;
          r_clear_v   <= 1'b1;
        end
        e_clear: begin
          if (r_clear_idx == lg_sets_lp'(sets_p - 1)) begin
            r_state     <= e_ready;
            r_clear_v   <= 1'b0;
            r_init_done <= 1'b1;
          end else begin
            r_clear_idx <= r_clear_idx + lg_sets_lp'(1);
          end
        end
        e_ready: r_state <= e_ready;
        default: begin
          r_state     <= e_reset;
          r_clear_v   <= 1'b0;
          r_init_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_clear_v   = r_clear_v;
  assign o_clear_idx = r_clear_idx;
  assign o_init_done = r_init_done;
  assign o_state     = r_state;

endmodule

// File: rtl/bp_lce_cache_mem_responder.sv
// Cache-side model of the LCE memory-packet ports: behavioural tag/data/stat arrays
// that yield to the cache pipeline. BP_LCE_MEM_RESP_STALL_EN adds LFSR random stalls.
module bp_lce_cache_mem_responder
  import bp_me_pkg::*;
#(
  parameter int sets_p        = 64,
  parameter int assoc_p       = 8,
  parameter int block_width_p = 512,
  parameter int ctag_width_p  = 28,
  parameter int state_width_p = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    cache_busy_i,
  output logic                    init_done_o,
  output bp_lce_mem_clear_state_e dbg_state_o,
  bp_lce_cache_mem_responder_if.slave mem_if
);

  localparam int lg_sets_lp  = $clog2(sets_p);
  localparam int tag_entry_w = ctag_width_p + state_width_p;
  localparam int lru_w       = assoc_p - 1;

  localparam logic [tag_entry_w-1:0] tag_entry_clr =
    {ctag_width_p'(0), state_width_p'(e_COH_I)};

  logic                  w_clear_v;
  logic [lg_sets_lp-1:0] w_clear_idx;
  logic                  w_init_done;
  logic                  w_busy;
  logic                  w_serve;
  logic                  w_tag_yumi;
  logic                  w_data_yumi;
  logic                  w_stat_yumi;

  bp_lce_mem_clear_fsm #(.sets_p(sets_p)) u_clear_fsm (
    .i_clk       (clk_i),
    .i_reset_n   (reset_n_i),
    .o_clear_v   (w_clear_v),
    .o_clear_idx (w_clear_idx),
    .o_init_done (w_init_done),
    .o_state     (dbg_state_o)
  );

`ifdef BP_LCE_MEM_RESP_STALL_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_lfsr <= 16'hACE1;
    end else if (w_init_done) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_busy = cache_busy_i | (r_lfsr[1:0] == 2'b00);
`else
  assign w_busy = cache_busy_i;
`endif

  // Reset gates yumi directly so nothing is consumed in the cycle reset is asserted.
  assign w_serve     = reset_n_i & w_init_done & ~w_busy;
  assign w_tag_yumi  = mem_if.tag_mem_pkt_v_i  & w_serve;
  assign w_data_yumi = mem_if.data_mem_pkt_v_i & w_serve;
  assign w_stat_yumi = mem_if.stat_mem_pkt_v_i & w_serve;

  assign mem_if.tag_mem_pkt_yumi_o  = w_tag_yumi;
  assign mem_if.data_mem_pkt_yumi_o = w_data_yumi;
  assign mem_if.stat_mem_pkt_yumi_o = w_stat_yumi;
  assign init_done_o                = w_init_done;

  logic [tag_entry_w-1:0]   r_tag_mem   [sets_p][assoc_p];
  logic [block_width_p-1:0] r_data_mem  [sets_p][assoc_p];
  logic [lru_w-1:0]         r_lru_mem   [sets_p];
  logic [assoc_p-1:0]       r_dirty_mem [sets_p];

  // Array writes; contents are intentionally not reset, the clear walk initialises them.
  always_ff @(posedge clk_i) begin
    if (w_clear_v) begin
      for (int w = 0; w < assoc_p; w++) begin
        r_tag_mem[w_clear_idx][w] <= tag_entry_clr;
      end
      r_lru_mem[w_clear_idx]   <= '0;
      r_dirty_mem[w_clear_idx] <= '0;
    end else begin
      if (w_tag_yumi) begin
        case (mem_if.tag_mem_pkt_opcode_i)
          e_tag_mem_set_clear: begin
            for (int w = 0; w < assoc_p; w++) begin
              r_tag_mem[mem_if.tag_mem_pkt_index_i][w] <= tag_entry_clr;
            end
          end
          e_tag_mem_set_tag:
            r_tag_mem[mem_if.tag_mem_pkt_index_i][mem_if.tag_mem_pkt_way_i] <=
              {mem_if.tag_mem_pkt_tag_i, mem_if.tag_mem_pkt_state_i};
          e_tag_mem_set_state:
            r_tag_mem[mem_if.tag_mem_pkt_index_i][mem_if.tag_mem_pkt_way_i][state_width_p-1:0] <=
              mem_if.tag_mem_pkt_state_i;
          default: ;
        endcase
      end
      if (w_data_yumi && (mem_if.data_mem_pkt_opcode_i == e_data_mem_write)) begin
        r_data_mem[mem_if.data_mem_pkt_index_i][mem_if.data_mem_pkt_way_i] <=
          mem_if.data_mem_pkt_data_i;
      end
      // LRU belongs to the cache pipeline; only clear-set touches it here.
      if (w_stat_yumi) begin
        case (mem_if.stat_mem_pkt_opcode_i)
          e_stat_mem_set_clear: begin
            r_lru_mem[mem_if.stat_mem_pkt_index_i]   <= '0;
            r_dirty_mem[mem_if.stat_mem_pkt_index_i] <= '0;
          end
          e_stat_mem_clear_dirty:
            r_dirty_mem[mem_if.stat_mem_pkt_index_i][mem_if.stat_mem_pkt_way_i] <= 1'b0;
          e_stat_mem_set_dirty:
            r_dirty_mem[mem_if.stat_mem_pkt_index_i][mem_if.stat_mem_pkt_way_i] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  logic [tag_entry_w-1:0]   r_tag_rd;
  logic [block_width_p-1:0] r_data_rd;
  logic [lru_w+assoc_p-1:0] r_stat_rd;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_tag_rd  <= '0;
      r_data_rd <= '0;
      r_stat_rd <= '0;
    end else begin
      if (w_tag_yumi && (mem_if.tag_mem_pkt_opcode_i == e_tag_mem_read)) begin
        r_tag_rd <= r_tag_mem[mem_if.tag_mem_pkt_index_i][mem_if.tag_mem_pkt_way_i];
      end
      if (w_data_yumi && (mem_if.data_mem_pkt_opcode_i == e_data_mem_read)) begin
        r_data_rd <= r_data_mem[mem_if.data_mem_pkt_index_i][mem_if.data_mem_pkt_way_i];
      end
      if (w_stat_yumi && (mem_if.stat_mem_pkt_opcode_i == e_stat_mem_read)) begin
        r_stat_rd <= {r_lru_mem[mem_if.stat_mem_pkt_index_i],
                      r_dirty_mem[mem_if.stat_mem_pkt_index_i]};
      end
    end
  end

  assign mem_if.tag_mem_o  = r_tag_rd;
  assign mem_if.data_mem_o = r_data_rd;
  assign mem_if.stat_mem_o = r_stat_rd;

endmodule

// File: tb/tb_bp_lce_cache_mem_responder.sv
// Directed bench for bp_lce_cache_mem_responder: vector table of packet operations
// plus hand sequences for init timing, busy stalls, concurrent packets and mid-clear reset.
module tb_bp_lce_cache_mem_responder;
  import bp_me_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  logic cache_busy;
  logic init_done;
  bp_lce_mem_clear_state_e dbg_state;

  always #5 clk = ~clk;

  bp_lce_cache_mem_responder_if mem_if ();

  bp_lce_cache_mem_responder dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .cache_busy_i (cache_busy),
    .init_done_o  (init_done),
    .dbg_state_o  (dbg_state),
    .mem_if       (mem_if)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [511:0] exp_q[$];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] read_out(input logic [1:0] arr);
    case (arr)
      2'd0:    return 512'(mem_if.tag_mem_o);
      2'd1:    return mem_if.data_mem_o;
      default: return 512'(mem_if.stat_mem_o);
    endcase
  endfunction

  function automatic logic yumi_of(input logic [1:0] arr);
    case (arr)
      2'd0:    return mem_if.tag_mem_pkt_yumi_o;
      2'd1:    return mem_if.data_mem_pkt_yumi_o;
      default: return mem_if.stat_mem_pkt_yumi_o;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_pkt(input logic [1:0] arr, input logic [1:0] op, input logic [5:0] idx,
                           input logic [2:0] way, input logic [27:0] tag, input logic [2:0] st,
                           input logic [511:0] data);
    case (arr)
      2'd0: begin
        mem_if.tag_mem_pkt_opcode_i = op;
        mem_if.tag_mem_pkt_index_i  = idx;
        mem_if.tag_mem_pkt_way_i    = way;
        mem_if.tag_mem_pkt_tag_i    = tag;
        mem_if.tag_mem_pkt_state_i  = st;
        mem_if.tag_mem_pkt_v_i      = 1'b1;
      end
      2'd1: begin
        mem_if.data_mem_pkt_opcode_i = op[0];
        mem_if.data_mem_pkt_index_i  = idx;
        mem_if.data_mem_pkt_way_i    = way;
        mem_if.data_mem_pkt_data_i   = data;
        mem_if.data_mem_pkt_v_i      = 1'b1;
      end
      default: begin
        mem_if.stat_mem_pkt_opcode_i = op;
        mem_if.stat_mem_pkt_index_i  = idx;
        mem_if.stat_mem_pkt_way_i    = way;
        mem_if.stat_mem_pkt_v_i      = 1'b1;
      end
    endcase
  endtask

  task automatic idle_all();
    mem_if.tag_mem_pkt_v_i  = 1'b0;
    mem_if.data_mem_pkt_v_i = 1'b0;
    mem_if.stat_mem_pkt_v_i = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the consuming edge.
  task automatic send(input logic [1:0] arr, input logic [1:0] op, input logic [5:0] idx,
                      input logic [2:0] way, input logic [27:0] tag, input logic [2:0] st,
                      input logic [511:0] data);
    int waited;
    logic got;
    drive_pkt(arr, op, idx, way, tag, st, data);
    got = 1'b0;
    waited = 0;
    #1;
    while (!got && waited < 20) begin
      if (yumi_of(arr)) got = 1'b1;
      else begin
        @(negedge clk);
        #1;
        waited++;
      end
    end
    if (got) @(posedge clk);
    else begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: no yumi on array %0d after %0d cycles", arr, waited);
    end
    @(negedge clk);
    idle_all();
  endtask

  // Counts rising edges from now until init_done is seen; v held high on tag to prove no yumi.
  task automatic wait_init(output int cnt, output logic yumi_seen);
    cnt = 0;
    yumi_seen = 1'b0;
    mem_if.tag_mem_pkt_v_i      = 1'b1;
    mem_if.tag_mem_pkt_opcode_i = 2'd3;
    while (!init_done && cnt < 200) begin
      if (mem_if.tag_mem_pkt_yumi_o) yumi_seen = 1'b1;
      @(posedge clk);
      #1;
      cnt++;
    end
    mem_if.tag_mem_pkt_v_i = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]   arr;   // 0 tag, 1 data, 2 stat
    logic [1:0]   op;
    logic [5:0]   idx;
    logic [2:0]   way;
    logic [27:0]  tag;
    logic [2:0]   st;
    logic [511:0] data;
    logic         chk;
    logic [511:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] arr, input logic [1:0] op, input logic [5:0] idx,
                              input logic [2:0] way, input logic [27:0] tag, input logic [2:0] st,
                              input logic [511:0] data, input logic chk, input logic [511:0] exp);
    vec_t v;
    v.arr = arr; v.op = op; v.idx = idx; v.way = way; v.tag = tag;
    v.st = st; v.data = data; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  logic [511:0] ones;
  logic [511:0] pat_a5;
  logic [511:0] pat_3c;
  int cnt;
  logic yumi_seen;

  initial begin
    ones   = '1;
    pat_a5 = {64{8'hA5}};
    pat_3c = {64{8'h3C}};

    vecs.push_back(mk(0, 1, 5, 3, 28'h0ABCDEF, 3'd3, '0, 0, '0));
    vecs.push_back(mk(0, 3, 5, 3, '0, '0, '0, 1, 512'({28'h0ABCDEF, 3'd3})));
    vecs.push_back(mk(0, 3, 5, 2, '0, '0, '0, 1, '0));
    vecs.push_back(mk(0, 2, 5, 3, 28'h1111111, 3'd6, '0, 0, '0));
    vecs.push_back(mk(0, 3, 5, 3, '0, '0, '0, 1, 512'({28'h0ABCDEF, 3'd6})));
    vecs.push_back(mk(1, 0, 63, 7, '0, '0, ones, 0, '0));
    vecs.push_back(mk(1, 1, 63, 7, '0, '0, '0, 1, ones));
    vecs.push_back(mk(1, 0, 0, 0, '0, '0, pat_a5, 0, '0));
    vecs.push_back(mk(1, 1, 0, 0, '0, '0, '0, 1, pat_a5));
    vecs.push_back(mk(1, 1, 63, 7, '0, '0, '0, 1, ones));
    vecs.push_back(mk(0, 1, 63, 7, 28'h1234567, 3'd2, '0, 0, '0));
    vecs.push_back(mk(0, 3, 63, 7, '0, '0, '0, 1, 512'({28'h1234567, 3'd2})));
    vecs.push_back(mk(0, 0, 63, 0, 28'hFFFFFFF, 3'd7, '0, 0, '0));
    vecs.push_back(mk(0, 3, 63, 7, '0, '0, '0, 1, 512'({28'h0, 3'd0})));
    vecs.push_back(mk(2, 2, 10, 5, '0, '0, '0, 0, '0));
    vecs.push_back(mk(2, 3, 10, 0, '0, '0, '0, 1, 512'(15'h0020)));
    vecs.push_back(mk(2, 1, 10, 5, '0, '0, '0, 0, '0));
    vecs.push_back(mk(2, 3, 10, 0, '0, '0, '0, 1, '0));
    vecs.push_back(mk(2, 2, 10, 0, '0, '0, '0, 0, '0));
    vecs.push_back(mk(2, 2, 10, 7, '0, '0, '0, 0, '0));
    vecs.push_back(mk(2, 3, 10, 0, '0, '0, '0, 1, 512'(15'h0081)));
    vecs.push_back(mk(2, 0, 10, 3, '0, '0, '0, 0, '0));
    vecs.push_back(mk(2, 3, 10, 0, '0, '0, '0, 1, '0));

    // ---- reset state ----
    reset_n    = 1'b0;
    cache_busy = 1'b0;
    idle_all();
    drive_pkt(2'd0, 2'd3, 6'd0, 3'd0, '0, '0, '0);
    drive_pkt(2'd1, 2'd1, 6'd0, 3'd0, '0, '0, '0);
    drive_pkt(2'd2, 2'd3, 6'd0, 3'd0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset_init_done", 512'(init_done), '0);
    check("reset_tag_yumi", 512'(mem_if.tag_mem_pkt_yumi_o), '0);
    check("reset_data_yumi", 512'(mem_if.data_mem_pkt_yumi_o), '0);
    check("reset_stat_yumi", 512'(mem_if.stat_mem_pkt_yumi_o), '0);
    check("reset_tag_mem_o", 512'(mem_if.tag_mem_o), '0);
    check("reset_data_mem_o", mem_if.data_mem_o, '0);
    check("reset_stat_mem_o", 512'(mem_if.stat_mem_o), '0);
    check("reset_state", 512'(dbg_state), 512'(e_reset));
    idle_all();

    // ---- init timing: first high edge enters clear, then 64 clear edges -> 65 ----
    reset_n = 1'b1;
    wait_init(cnt, yumi_seen);
    check("init_cycles", 512'(cnt), 512'(65));
    check("no_yumi_during_clear", 512'(yumi_seen), '0);
    check("ready_state", 512'(dbg_state), 512'(e_ready));

    // ---- table ----
    foreach (vecs[i]) begin
      send(vecs[i].arr, vecs[i].op, vecs[i].idx, vecs[i].way, vecs[i].tag, vecs[i].st,
           vecs[i].data);
      if (vecs[i].chk) begin
        exp_q.push_back(vecs[i].exp);
        check($sformatf("vec%0d", i), read_out(vecs[i].arr), exp_q.pop_front());
      end
    end

    // ---- data_mem_o holds across a write ----
    send(2'd1, 2'd0, 6'd0, 3'd0, '0, '0, pat_3c);
    check("data_hold", mem_if.data_mem_o, ones);
    send(2'd1, 2'd1, 6'd0, 3'd0, '0, '0, '0);
    check("data_overwrite", mem_if.data_mem_o, pat_3c);

    // ---- busy stalls a pending stat set-dirty for 4 cycles ----
    cache_busy = 1'b1;
    drive_pkt(2'd2, 2'd2, 6'd12, 3'd2, '0, '0, '0);
    yumi_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (mem_if.stat_mem_pkt_yumi_o) yumi_seen = 1'b1;
      @(negedge clk);
    end
    check("busy_yumi_low", 512'(yumi_seen), '0);
    cache_busy = 1'b0;
    #1;
    check("busy_release_yumi", 512'(mem_if.stat_mem_pkt_yumi_o), 512'(1));
    @(posedge clk);
    @(negedge clk);
    idle_all();
    send(2'd2, 2'd3, 6'd12, 3'd0, '0, '0, '0);
    check("busy_stat_read", 512'(mem_if.stat_mem_o), 512'(15'h0004));

    // ---- all three channels in one cycle ----
    drive_pkt(2'd0, 2'd3, 6'd5, 3'd3, '0, '0, '0);
    drive_pkt(2'd1, 2'd1, 6'd63, 3'd7, '0, '0, '0);
    drive_pkt(2'd2, 2'd3, 6'd10, 3'd0, '0, '0, '0);
    #1;
    check("tri_tag_yumi", 512'(mem_if.tag_mem_pkt_yumi_o), 512'(1));
    check("tri_data_yumi", 512'(mem_if.data_mem_pkt_yumi_o), 512'(1));
    check("tri_stat_yumi", 512'(mem_if.stat_mem_pkt_yumi_o), 512'(1));
    @(posedge clk);
    @(negedge clk);
    idle_all();
    check("tri_tag_mem_o", 512'(mem_if.tag_mem_o), 512'({28'h0ABCDEF, 3'd6}));
    check("tri_data_mem_o", mem_if.data_mem_o, ones);
    check("tri_stat_mem_o", 512'(mem_if.stat_mem_o), '0);

    // ---- reset pulsed at clear index 20 ----
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (21) @(negedge clk);
    check("midclear_state", 512'(dbg_state), 512'(e_clear));
    check("midclear_init_done", 512'(init_done), '0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midclear_reset_state", 512'(dbg_state), 512'(e_reset));
    reset_n = 1'b1;
    wait_init(cnt, yumi_seen);
    check("reinit_cycles", 512'(cnt), 512'(65));
    check("reinit_no_yumi", 512'(yumi_seen), '0);
    send(2'd0, 2'd3, 6'd5, 3'd3, '0, '0, '0);
    check("reinit_tag_cleared", 512'(mem_if.tag_mem_o), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
